data_mem_ctrl: RTL and testbench
================================

Name: data_mem_ctrl

Overview:
Parametrised word-addressed data memory for the RISC datapath, with byte-lane writes, a registered read port and a request/ready handshake. A hardware clear sequencer zeroes the array after reset and on demand. Out-of-range accesses are flagged. A debug tap exposes the low bits of the first words for board display.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of 8
ADDR_WIDTH, 32, byte-address width of ma
DEPTH, 64, number of words; must be >= 2
DBG_WORDS, 8, number of words exported on dbg
DBG_BITS, 4, low bits taken from each exported word; DBG_WORDS*DBG_BITS <= DATA_WIDTH

Ports:
clock  in  1  system clock; all state changes on rising edge
reset  in  1  asynchronous, active-low reset
mreq  in  1  access request
mwr  in  1  1 = write, 0 = read; sampled with mreq
moe  in  1  read output enable; sampled with mreq
ma  in  ADDR_WIDTH  byte address; word index = ma >> 2; ma[1:0] ignored
mwd  in  DATA_WIDTH  write data
mbe  in  DATA_WIDTH/8  byte-lane write enables; bit k covers mwd[8k+7:8k]
clear  in  1  start a clear sweep; single-cycle pulse or level
mready  out  1  access accepted this cycle when mreq && mready
mrd  out  DATA_WIDTH  registered read data
mvalid  out  1  one-cycle pulse: mrd updated
merr  out  1  one-cycle pulse: accepted access was out of range
clear_busy  out  1  clear sweep in progress
dbg  out  DBG_WORDS*DBG_BITS  {word[DBG_WORDS-1][DBG_BITS-1:0], ..., word[0][DBG_BITS-1:0]}

Behaviour:
- FSM states: CLEAR and READY. Counter cidx is $clog2(DEPTH) bits wide.
- While reset = 0 (asynchronous):
  - state = CLEAR, cidx = 0.
  - mrd = 0, mvalid = 0, merr = 0.
  - mready = 0, clear_busy = 1.
  - Array contents are not reset directly.
- CLEAR state:
  - Each cycle writes 0 to word[cidx] and increments cidx.
  - After cidx = DEPTH-1 is written, go to READY. The sweep takes exactly DEPTH cycles from reset release.
  - mready = 0; requests are ignored and produce no mvalid or merr.
- READY state:
  - clear_busy = 0.
  - mready = !clear (combinational). clear has priority over a same-cycle mreq; that request is not accepted.
  - clear = 1 moves the FSM to CLEAR with cidx = 0.
- Accepted write, in range (word index < DEPTH):
  - Lanes with mbe[k] = 1 are updated at the same edge; other lanes are preserved.
  - No mvalid pulse. mbe = 0 is a legal no-op.
- Accepted read, in range:
  - At the next edge, mrd = moe ? word[idx] : 0, and mvalid = 1 for one cycle. Latency is 1 cycle.
  - mrd holds its value until the next accepted read.
- Read-after-write to the same word in consecutive cycles returns the new data. Back-to-back reads sustain one per cycle.
- Out-of-range access (word index >= DEPTH; compare the full shifted address with no truncation):
  - Write: dropped; merr pulses 1 cycle after accept.
  - Read: mrd = 0; mvalid and merr both pulse 1 cycle after accept.
- An in-range accept produces merr = 0.
- clear asserted during CLEAR restarts the sweep at cidx = 0.
- Reset asserted mid-sweep or mid-access: the pending mvalid/merr is lost, and the sweep restarts from 0 on release.
- dbg is combinational from the array. It reads all-zero once the first sweep completes.

Test Plan:
1. Release reset, hold mreq = 1 -> mready = 0 and clear_busy = 1 for exactly 64 cycles, then mready = 1 and clear_busy = 0; read of ma = 0x0 returns mrd = 0 with mvalid = 1.
2. Write ma = 0x8, mwd = 0xDEADBEEF, mbe = 4'hF; next cycle read 0x8 -> mrd = 0xDEADBEEF one cycle later. Then write mwd = 0x000000AA, mbe = 4'h1 and read 0x8 -> mrd = 0xDEADBEAA.
3. Read ma = 0x100 (index 64) -> mvalid = 1, merr = 1, mrd = 0. Write to 0x100 -> merr = 1, mvalid = 0, and word 0 is unchanged.
4. Write words 0..7 with values 1..8, then read -> dbg = 32'h87654321. Read of word 3 with moe = 0 -> mrd = 0, mvalid = 1.
5. Pulse clear on the same cycle as mreq -> access not accepted. After 64 cycles all words read 0 and dbg = 0.
6. Assert reset at cycle 20 of a sweep -> outputs go to their reset values immediately; on release the full 64-cycle sweep repeats.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// Word-addressed data memory with byte-lane writes, registered read port,
// request/ready handshake, hardware clear sweep and a debug tap on the low words.
module data_mem_ctrl #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DEPTH      = 64,
   parameter int unsigned DBG_WORDS  = 8,
   parameter int unsigned DBG_BITS   = 4
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic                            mreq,
   input  logic                            mwr,
   input  logic                            moe,
   input  logic [ADDR_WIDTH-1:0]           ma,
   input  logic [DATA_WIDTH-1:0]           mwd,
   input  logic [DATA_WIDTH/8-1:0]         mbe,
   input  logic                            clear,
   output logic                            mready,
   output logic [DATA_WIDTH-1:0]           mrd,
   output logic                            mvalid,
   output logic                            merr,
   output logic                            clear_busy,
   output logic [DBG_WORDS*DBG_BITS-1:0]   dbg
);

   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned LANES = DATA_WIDTH / 8;
   localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);
   localparam logic [IDX_W-1:0]      LAST    = IDX_W'(DEPTH - 1);

   typedef enum logic {CLEAR, READY} state_t;

   state_t                  state;
   logic [IDX_W-1:0]        cidx;
   logic [DATA_WIDTH-1:0]   mem [DEPTH];
   logic [ADDR_WIDTH-1:0]   widx;
   logic [IDX_W-1:0]        idx;
   logic                    in_range;
   logic                    accept;

   // Range test uses the full shifted address so high address bits cannot alias.
   always_comb begin
      widx       = ma >> 2;
      in_range   = widx < DEPTH_A;
      idx        = widx[IDX_W-1:0];
      mready     = (state == READY) && !clear;
      clear_busy = (state == CLEAR);
      accept     = mreq && mready;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state  <= CLEAR;
         cidx   <= '0;
         mrd    <= '0;
         mvalid <= 1'b0;
         merr   <= 1'b0;
      end else begin
         mvalid <= 1'b0;
         merr   <= 1'b0;
         case (state)
            CLEAR: begin
               if (clear) begin
                  cidx <= '0;
               end else if (cidx == LAST) begin
                  state <= READY;
                  cidx  <= '0;
               end else begin
                  cidx <= cidx + 1'b1;
               end
            end
            READY: begin
               if (clear) begin
                  state <= CLEAR;
                  cidx  <= '0;
               end else if (accept) begin
                  merr <= !in_range;
                  if (!mwr) begin
                     mvalid <= 1'b1;
                     mrd    <= (in_range && moe) ? mem[idx] : '0;
                  end
               end
            end
            default: begin
               state <= CLEAR;
               cidx  <= '0;
            end
         endcase
      end
   end

   // Array has no reset; the sweep zeroes it one word per cycle instead.
   always_ff @(posedge clock) begin
      if (state == CLEAR) begin
         mem[cidx] <= '0;
      end else if (accept && mwr && in_range) begin
         for (int unsigned k = 0; k < LANES; k++) begin
            if (mbe[k]) mem[idx][8*k +: 8] <= mwd[8*k +: 8];
         end
      end
   end

   for (genvar g = 0; g < DBG_WORDS; g++) begin : g_dbg
      assign dbg[g*DBG_BITS +: DBG_BITS] = mem[g][DBG_BITS-1:0];
   end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: vector table, directed corner sequences
// and random traffic against a behavioural memory model.
module tb_data_mem_ctrl;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        mreq = 1'b0, mwr = 1'b0, moe = 1'b0, clear = 1'b0;
   logic [31:0] ma = '0, mwd = '0;
   logic [3:0]  mbe = '0;
   logic        mready, mvalid, merr, clear_busy;
   logic [31:0] mrd, dbg;

   int checks = 0;
   int errors = 0;

   data_mem_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(64), .DBG_WORDS(8), .DBG_BITS(4)) dut (
      .clock(clock), .reset(reset), .mreq(mreq), .mwr(mwr), .moe(moe), .ma(ma),
      .mwd(mwd), .mbe(mbe), .clear(clear), .mready(mready), .mrd(mrd),
      .mvalid(mvalid), .merr(merr), .clear_busy(clear_busy), .dbg(dbg));

   always #5 clock = ~clock;

   // Model: remaining sweep cycles (0 = ready), word array, expected registered outputs.
   int          sweep_left;
   logic [31:0] mm [64];
   logic [31:0] e_mrd;
   logic        e_mv, e_me;

   typedef struct {
      logic        req, wr, oe;
      logic [31:0] a, wd;
      logic [3:0]  be;
      logic        e_v, e_e;
      logic [31:0] e_rd;
   } vec_t;
   vec_t tbl [15];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic drive(input logic rq, input logic wr, input logic oe, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] be, input logic clr);
      mreq = rq; mwr = wr; moe = oe; ma = a; mwd = wd; mbe = be; clear = clr;
   endtask

   // Called at posedge+1 with inputs applied; returns at the next posedge+1.
   task automatic cycle();
      logic [31:0] edbg;
      logic [31:0] w;
      #1;
      chk("mready", mready, (sweep_left == 0) && !clear);
      chk("clear_busy", clear_busy, sweep_left != 0);
      if (sweep_left == 0) begin
         edbg = '0;
         for (int i = 0; i < 8; i++) edbg[4*i +: 4] = mm[i][3:0];
         chk("dbg", dbg, edbg);
      end
      e_mv = 1'b0;
      e_me = 1'b0;
      if (sweep_left > 0) begin
         if (clear) sweep_left = 64;
         else begin
            sweep_left--;
            if (sweep_left == 0) for (int i = 0; i < 64; i++) mm[i] = '0;
         end
      end else if (clear) begin
         sweep_left = 64;
      end else if (mreq) begin
         w = ma >> 2;
         if (w < 64) begin
            if (mwr) begin
               for (int k = 0; k < 4; k++) if (mbe[k]) mm[w][8*k +: 8] = mwd[8*k +: 8];
            end else begin
               e_mrd = moe ? mm[w] : 32'h0;
               e_mv  = 1'b1;
            end
         end else begin
            e_me = 1'b1;
            if (!mwr) begin
               e_mv  = 1'b1;
               e_mrd = '0;
            end
         end
      end
      @(posedge clock); #1;
      chk("mrd", mrd, e_mrd);
      chk("mvalid", mvalid, e_mv);
      chk("merr", merr, e_me);
   endtask

   // Called at posedge+1; asserts reset asynchronously and releases it a cycle later.
   task automatic do_reset();
      reset = 1'b0;
      #1;
      chk("rst_mrd", mrd, 0);
      chk("rst_mvalid", mvalid, 0);
      chk("rst_merr", merr, 0);
      chk("rst_mready", mready, 0);
      chk("rst_clear_busy", clear_busy, 1);
      e_mrd = '0; e_mv = 1'b0; e_me = 1'b0;
      sweep_left = 64;
      @(posedge clock); #1;
      reset = 1'b1;
   endtask

   task automatic count_sweep(input string nm);
      int n;
      n = 0;
      while (clear_busy === 1'b1 && n < 200) begin
         cycle();
         n++;
      end
      chk(nm, n, 64);
   endtask

   initial begin
      int r;
      logic [31:0] a;
      for (int i = 0; i < 64; i++) mm[i] = '0;

      tbl[0]  = '{1'b1, 1'b0, 1'b1, 32'h0000_0000, 32'h0,         4'h0, 1'b1, 1'b0, 32'h0};
      tbl[1]  = '{1'b1, 1'b1, 1'b0, 32'h0000_0008, 32'hDEADBEEF,  4'hF, 1'b0, 1'b0, 32'h0};
      tbl[2]  = '{1'b1, 1'b0, 1'b1, 32'h0000_0008, 32'h0,         4'h0, 1'b1, 1'b0, 32'hDEADBEEF};
      tbl[3]  = '{1'b1, 1'b1, 1'b0, 32'h0000_0008, 32'h0000_00AA, 4'h1, 1'b0, 1'b0, 32'hDEADBEEF};
      tbl[4]  = '{1'b1, 1'b0, 1'b1, 32'h0000_0008, 32'h0,         4'h0, 1'b1, 1'b0, 32'hDEADBEAA};
      tbl[5]  = '{1'b1, 1'b0, 1'b1, 32'h0000_0100, 32'h0,         4'h0, 1'b1, 1'b1, 32'h0};
      tbl[6]  = '{1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h12345678,  4'hF, 1'b0, 1'b1, 32'h0};
      tbl[7]  = '{1'b1, 1'b0, 1'b1, 32'h0000_0000, 32'h0,         4'h0, 1'b1, 1'b0, 32'h0};
      tbl[8]  = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0,         4'h0, 1'b0, 1'b0, 32'h0};
      tbl[9]  = '{1'b1, 1'b1, 1'b0, 32'h0000_000C, 32'h11223344,  4'h0, 1'b0, 1'b0, 32'h0};
      tbl[10] = '{1'b1, 1'b0, 1'b1, 32'h0000_000C, 32'h0,         4'h0, 1'b1, 1'b0, 32'h0};
      tbl[11] = '{1'b1, 1'b0, 1'b1, 32'h0000_000A, 32'h0,         4'h0, 1'b1, 1'b0, 32'hDEADBEAA};
      tbl[12] = '{1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0,         4'h0, 1'b1, 1'b1, 32'h0};
      tbl[13] = '{1'b1, 1'b1, 1'b0, 32'h4000_00FC, 32'h5A5A5A5A,  4'hF, 1'b0, 1'b1, 32'h0};
      tbl[14] = '{1'b1, 1'b0, 1'b1, 32'h0000_00FC, 32'h0,         4'h0, 1'b1, 1'b0, 32'h0};

      @(posedge clock); #1;
      do_reset();

      // Initial sweep with a read request held the whole time.
      drive(1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 1'b0);
      count_sweep("init_sweep_len");

      foreach (tbl[i]) begin
         drive(tbl[i].req, tbl[i].wr, tbl[i].oe, tbl[i].a, tbl[i].wd, tbl[i].be, 1'b0);
         cycle();
         chk("tbl_mrd", mrd, tbl[i].e_rd);
         chk("tbl_mvalid", mvalid, tbl[i].e_v);
         chk("tbl_merr", merr, tbl[i].e_e);
      end

      // Debug tap after writing 1..8 into words 0..7.
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 1'b1, 1'b0, 32'(i * 4), 32'(i + 1), 4'hF, 1'b0);
         cycle();
      end
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
      #1;
      chk("dbg_pattern", dbg, 32'h87654321);
      drive(1'b1, 1'b0, 1'b0, 32'hC, 32'h0, 4'h0, 1'b0);
      cycle();
      chk("moe0_mrd", mrd, 0);
      chk("moe0_mvalid", mvalid, 1);

      // clear beats a same-cycle write; full sweep then everything reads zero.
      drive(1'b1, 1'b1, 1'b0, 32'h0, 32'hFFFF_FFFF, 4'hF, 1'b1);
      #1;
      chk("clear_blocks_mready", mready, 0);
      cycle();
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
      count_sweep("clear_sweep_len");
      for (int i = 0; i < 64; i++) begin
         drive(1'b1, 1'b0, 1'b1, 32'(i * 4), 32'h0, 4'h0, 1'b0);
         cycle();
      end
      chk("dbg_cleared", dbg, 0);

      // Random traffic.
      for (int n = 0; n < 1500; n++) begin
         r = $urandom_range(0, 9);
         if (r < 8)       a = {24'h0, 6'($urandom_range(0, 63)), 2'($urandom)};
         else if (r == 8) a = ($urandom_range(64, 1000) << 2) | 32'($urandom_range(0, 3));
         else             a = $urandom | 32'hF000_0000;
         drive($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 5) != 0, a,
               $urandom, 4'($urandom), $urandom_range(0, 60) == 0);
         cycle();
      end

      // Reset with a pending read result, then again mid-sweep.
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
      while (clear_busy === 1'b1 && sweep_left > 0) cycle();
      drive(1'b1, 1'b0, 1'b1, 32'h8, 32'h0, 4'h0, 1'b0);
      cycle();
      chk("pre_reset_mvalid", mvalid, 1);
      do_reset();
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
      for (int i = 0; i < 20; i++) cycle();
      do_reset();
      count_sweep("resweep_len");
      drive(1'b1, 1'b0, 1'b1, 32'h8, 32'h0, 4'h0, 1'b0);
      cycle();
      chk("post_reset_read", mrd, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
